game_control: RTL

//   Sequencing FSM for the basketball game datapath. Turns start/shot/name-entry

---
 rtl/game_control.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/game_control.sv
// Sequencing FSM for the basketball game: turns start/shot/name-entry events into
// one-cycle datapath load strobes, runs the round timer and a saturating shot count.
// Optional `define SHOT_DEBOUNCE_EN adds a stable-high debounce filter on shot.
module game_control #(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int GAME_SECONDS    = 60,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       shot,
  input  logic       name_done,
  output logic       ld_reset,
  output logic       ld_wait,
  output logic       ld_one,
  output logic       ld_ten,
  output logic       ld_save,
  output logic       playing,
  output logic       name_entry,
  output logic [6:0] time_left
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] TIME_INIT = 7'(GAME_SECONDS);
  localparam logic [6:0] SHOT_MAX  = 7'd99;

  typedef enum logic [3:0] {
    S_CLEAR, S_IDLE, S_WAIT, S_PLAY, S_ONE, S_TEN, S_OVER, S_NAME, S_SAVE
  } state_t;

  state_t        state, state_nx;
  logic          start_q, sync1, sync2, shot_edge;
  logic          pending, active, tick, expire;
  logic [PW-1:0] presc;
  logic [6:0]    shot_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
    end else begin
      start_q <= start;
      sync1   <= shot;
      sync2   <= sync1;
    end
  end

`ifdef SHOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_FULL = DW'(DEBOUNCE_CYCLES);
  logic [DW-1:0] db_cnt;

  // Counts consecutive high cycles; the edge fires once, on the last required one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               db_cnt <= '0;
    else if (!sync2)           db_cnt <= '0;
    else if (db_cnt != DB_FULL) db_cnt <= db_cnt + 1'b1;
  end
  assign shot_edge = sync2 && (db_cnt == DB_LAST);
`else
  logic sync3;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync3 <= 1'b0;
    else         sync3 <= sync2;
  end
  assign shot_edge = sync2 & ~sync3;
`endif

  assign active = (state == S_PLAY) || (state == S_ONE) || (state == S_TEN);
  assign tick   = active && (presc == PRESC_LAST);
  assign expire = tick && (time_left == 7'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_CLEAR;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ld_reset   = 1'b0;
    ld_wait    = 1'b0;
    ld_one     = 1'b0;
    ld_ten     = 1'b0;
    ld_save    = 1'b0;
    playing    = 1'b0;
    name_entry = 1'b0;
    case (state)
      S_CLEAR: begin
        ld_reset = 1'b1;
        state_nx = S_IDLE;
      end
      S_IDLE: if (start && !start_q) state_nx = S_WAIT;
      S_WAIT: begin
        ld_wait  = 1'b1;
        state_nx = S_PLAY;
      end
      S_PLAY: begin
        playing = 1'b1;
        // Expiry wins over a same-cycle shot so the final edge is never scored.
        if (expire || time_left == 7'd0)
          state_nx = S_OVER;
        else if ((pending || shot_edge) && shot_cnt < SHOT_MAX)
          state_nx = S_ONE;
      end
      S_ONE: begin
        playing  = 1'b1;
        ld_one   = 1'b1;
        state_nx = S_TEN;
      end
      S_TEN: begin
        playing  = 1'b1;
        ld_ten   = 1'b1;
        state_nx = (expire || time_left == 7'd0) ? S_OVER : S_PLAY;
      end
      S_OVER: state_nx = S_NAME;
      S_NAME: begin
        name_entry = 1'b1;
        if (name_done) state_nx = S_SAVE;
      end
      S_SAVE: begin
        ld_save  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  // PLAY always consumes pending; edges seen in ONE/TEN are held one deep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else begin
      case (state)
        S_ONE, S_TEN: begin
          if (state_nx == S_OVER) pending <= 1'b0;
          else if (shot_edge)     pending <= 1'b1;
        end
        default: pending <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc     <= '0;
      time_left <= TIME_INIT;
      shot_cnt  <= 7'd0;
    end else begin
      if (state == S_WAIT)  presc <= '0;
      else if (tick)        presc <= '0;
      else if (active)      presc <= presc + 1'b1;

      if (state == S_WAIT)                 time_left <= TIME_INIT;
      else if (tick && time_left != 7'd0)  time_left <= time_left - 7'd1;

      if (state == S_WAIT)                               shot_cnt <= 7'd0;
      else if (state == S_ONE && shot_cnt < SHOT_MAX)    shot_cnt <= shot_cnt + 7'd1;
    end
  end

endmodule
